// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared opcodes, FSM states and field widths for the register bank
package reg_bank_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LD  = 4'h1;
  localparam logic [OPW-1:0] OP_ADD = 4'h2;
  localparam logic [OPW-1:0] OP_SUB = 4'h3;
  localparam logic [OPW-1:0] OP_CLR = 4'h4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_SCRUB = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bank_alu.sv
// rtl/reg_bank_alu.sv - combinational LD/ADD/SUB datapath on the selected register
import reg_bank_pkg::*;

module reg_bank_alu #(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  // SUB yields the borrow in the extra bit: it is set exactly when imm > a
  always_comb begin
    result    = imm;
    carry_out = 1'b0;
    case (op)
      OP_ADD:  {carry_out, result} = {1'b0, a} + {1'b0, imm};
      OP_SUB:  {carry_out, result} = {1'b0, a} - {1'b0, imm};
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank_pn.sv
// rtl/reg_bank_pn.sv - parametrised register bank with ALU ops, carry, scrub and sticky error
import reg_bank_pkg::*;

module reg_bank_pn #(
  parameter  int NREGS = 4,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(NREGS),
  localparam int IW    = OPW + IDXW + WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IW-1:0]          inst,
  input  logic                   inst_en,
  output logic                   inst_ready,
  output logic                   carry,
  output logic                   error,
  output logic [NREGS*WIDTH-1:0] out
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

  state_t                             state, state_nxt;
  logic [NREGS-1:0][WIDTH-1:0]        regs;
  logic [IDXW-1:0]                    scrub_ctr;
  logic [OPW-1:0]                     op;
  logic [IDXW-1:0]                    idx;
  logic [WIDTH-1:0]                   imm;
  logic [WIDTH-1:0]                   alu_result;
  logic                               alu_carry;

  assign op  = inst[IW-1 -: OPW];
  assign idx = inst[WIDTH +: IDXW];
  assign imm = inst[WIDTH-1:0];

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op        (op),
    .a         (regs[idx]),
    .imm       (imm),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_nxt;
  end

  // inst_en while not ready (Reset or Scrub) is a protocol violation
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = inst_en ? ST_ERROR : ST_READY;
      ST_READY: begin
        if (inst_en) begin
          case (op)
            OP_NOP, OP_LD, OP_ADD, OP_SUB: state_nxt = ST_READY;
            OP_CLR:                        state_nxt = ST_SCRUB;
            default:                       state_nxt = ST_ERROR;
          endcase
        end
      end
      ST_SCRUB: begin
        if (inst_en)                     state_nxt = ST_ERROR;
        else if (scrub_ctr == LAST_IDX)  state_nxt = ST_READY;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_ERROR;
    endcase
  end

  // Entering or sitting in Error zeroes the bank on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs      <= '0;
      carry     <= 1'b0;
      scrub_ctr <= '0;
    end else if (state_nxt == ST_ERROR) begin
      regs      <= '0;
      carry     <= 1'b0;
      scrub_ctr <= '0;
    end else if (state == ST_READY && inst_en) begin
      case (op)
        OP_LD:  regs[idx] <= alu_result;
        OP_ADD, OP_SUB: begin
          regs[idx] <= alu_result;
          carry     <= alu_carry;
        end
        OP_CLR: scrub_ctr <= '0;
        default: ;
      endcase
    end else if (state == ST_SCRUB) begin
      regs[scrub_ctr] <= '0;
      scrub_ctr       <= scrub_ctr + 1'b1;
      if (scrub_ctr == LAST_IDX) carry <= 1'b0;
    end
  end

  assign inst_ready = (state == ST_READY);
  assign error      = (state == ST_ERROR);
  assign out        = regs;

endmodule
